// File: rtl/burst_pkg.sv
// Shared types and defaults for the burst sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package burst_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        ON    = 3'd2,
        OFF   = 3'd3,
        CONT  = 3'd4,
        DONE  = 3'd5
    } burst_state_t;

    localparam int DAC_WIDTH_DEFAULT = 14;
    localparam int CFG_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/burst_sequencer_if.sv
// Bundles control, config, sample stream and status of the burst sequencer.
// Latency: none (wiring only).
// Backpressure: none; the sample stream is free-running.
interface burst_sequencer_if
    import burst_pkg::*;
#(
    parameter int CFG_DATA_WIDTH = CFG_WIDTH_DEFAULT,
    parameter int DAC_WIDTH      = DAC_WIDTH_DEFAULT
) ();
    logic                      enable;
    logic                      trigger;
    logic [DAC_WIDTH-1:0]      dac_data;
    logic [CFG_DATA_WIDTH-1:0] cfg_delay;
    logic [CFG_DATA_WIDTH-1:0] cfg_on;
    logic [CFG_DATA_WIDTH-1:0] cfg_off;
    logic [CFG_DATA_WIDTH-1:0] cfg_repeat;
    logic [DAC_WIDTH-1:0]      dac_out;
    logic                      gate;
    logic                      busy;
    logic                      done;
    logic [CFG_DATA_WIDTH-1:0] burst_count;

    modport master (
        output enable, trigger, dac_data, cfg_delay, cfg_on, cfg_off, cfg_repeat,
        input  dac_out, gate, busy, done, burst_count
    );

    modport slave (
        input  enable, trigger, dac_data, cfg_delay, cfg_on, cfg_off, cfg_repeat,
        output dac_out, gate, busy, done, burst_count
    );
endinterface

// File: rtl/burst_trig_detect.sv
// Rising-edge detector for the start trigger, optional 2-flop synchronizer (BURST_SEQUENCER_TRIG_SYNC_EN).
// Latency: trig_edge is combinational from trigger; +2 cycles when the synchronizer is built in.
// Backpressure: none; edges are reported every cycle regardless of sequencer state.
module burst_trig_detect (
    input  logic clk,
    input  logic areset,
    input  logic trigger,
    output logic trig_edge
);
    logic trig_in;
    logic trig_q;

`ifdef BURST_SEQUENCER_TRIG_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer so an asynchronous trigger pin can be used.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trigger};
        end
    end

    assign trig_in = sync_q[1];
`else
    assign trig_in = trigger;
`endif

    // Trigger history; keeps updating while busy so a held trigger never restarts.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_in;
        end
    end

    assign trig_edge = trig_in & ~trig_q;

endmodule

// File: rtl/burst_sequencer.sv
// Gates the DAC sample stream into delay / on / off burst trains on a trigger (opt. BURST_SEQUENCER_TRIG_SYNC_EN).
// Latency: gate/dac_out registered, 1 cycle after the start edge and 1 cycle from dac_data.
// Backpressure: none; enable low aborts to IDLE, triggers while busy are ignored.
module burst_sequencer
    import burst_pkg::*;
#(
    parameter int CFG_DATA_WIDTH = CFG_WIDTH_DEFAULT,
    parameter int DAC_WIDTH      = DAC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             areset,
    burst_sequencer_if.slave bus
);
    localparam logic [CFG_DATA_WIDTH-1:0] ONE      = CFG_DATA_WIDTH'(1);
    localparam logic [CFG_DATA_WIDTH-1:0] ALL_ONES = '1;

    burst_state_t              state;
    burst_state_t              next_state;
    logic [CFG_DATA_WIDTH-1:0] cnt;
    logic [CFG_DATA_WIDTH-1:0] next_cnt;
    logic [CFG_DATA_WIDTH-1:0] lat_delay;
    logic [CFG_DATA_WIDTH-1:0] lat_on;
    logic [CFG_DATA_WIDTH-1:0] lat_off;
    logic [CFG_DATA_WIDTH-1:0] lat_repeat;
    logic [CFG_DATA_WIDTH-1:0] burst_cnt;
    logic [CFG_DATA_WIDTH-1:0] count_inc;
    logic [DAC_WIDTH-1:0]      dac_out_q;
    logic                      gate_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      trig_edge;
    logic                      start;
    logic                      bump;
    logic                      next_gate;

    burst_trig_detect u_trig_detect (
        .clk       (clk),
        .areset    (areset),
        .trigger   (bus.trigger),
        .trig_edge (trig_edge)
    );

    // Completed-burst count saturates instead of wrapping in infinite mode.
    assign count_inc = (burst_cnt == ALL_ONES) ? burst_cnt : burst_cnt + ONE;

    // Next-state and per-state cycle counter; counters compare against latched length-1.
    always_comb begin
        next_state = state;
        next_cnt   = cnt + ONE;
        start      = 1'b0;
        bump       = 1'b0;
        if (!bus.enable) begin
            next_state = IDLE;
            next_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_cnt = '0;
                    if (trig_edge) begin
                        start = 1'b1;
                        if (bus.cfg_on == '0) begin
                            next_state = CONT;
                        end else if (bus.cfg_delay != '0) begin
                            next_state = DELAY;
                        end else begin
                            next_state = ON;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == lat_delay - ONE) begin
                        next_state = ON;
                        next_cnt   = '0;
                    end
                end
                ON: begin
                    if (cnt == lat_on - ONE) begin
                        bump     = 1'b1;
                        next_cnt = '0;
                        if ((lat_repeat != '0) && (count_inc == lat_repeat)) begin
                            next_state = DONE;
                        end else if (lat_off != '0) begin
                            next_state = OFF;
                        end else begin
                            next_state = ON;
                        end
                    end
                end
                OFF: begin
                    if (cnt == lat_off - ONE) begin
                        next_state = ON;
                        next_cnt   = '0;
                    end
                end
                CONT: begin
                    next_cnt = '0;
                end
                DONE: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    assign next_gate = (next_state == ON) || (next_state == CONT);

    // State, config latch, burst counter and registered outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_delay  <= '0;
            lat_on     <= '0;
            lat_off    <= '0;
            lat_repeat <= '0;
            burst_cnt  <= '0;
            gate_q     <= 1'b0;
            dac_out_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            if (start) begin
                lat_delay  <= bus.cfg_delay;
                lat_on     <= bus.cfg_on;
                lat_off    <= bus.cfg_off;
                lat_repeat <= bus.cfg_repeat;
                burst_cnt  <= '0;
            end else if (bump) begin
                burst_cnt <= count_inc;
            end
            gate_q    <= next_gate;
            dac_out_q <= next_gate ? bus.dac_data : '0;
            busy_q    <= (next_state != IDLE);
            done_q    <= (next_state == DONE);
        end
    end

    assign bus.gate        = gate_q;
    assign bus.dac_out     = dac_out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.burst_count = burst_cnt;

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench: arithmetic burst-schedule model checked every cycle, plus directed literal checks.
// Latency: model predicts registered outputs one cycle after each sampled input edge.
// Backpressure: not applicable.
module tb_burst_sequencer;

`ifdef BURST_SEQUENCER_TRIG_SYNC_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b0;

    burst_sequencer_if #(.CFG_DATA_WIDTH(32), .DAC_WIDTH(14)) bus ();

    burst_sequencer #(.CFG_DATA_WIDTH(32), .DAC_WIDTH(14)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  th = '0;
    logic        tedge;
    bit          m_active = 0;
    bit          m_cont = 0;
    longint      m_k = 0, m_delay = 0, m_on = 0, m_off = 0, m_rep = 0, m_total = 0;
    longint      j, per, ph;
    logic        exp_gate = 0, exp_busy = 0, exp_done = 0;
    logic [13:0] exp_dac = '0;
    logic [31:0] exp_count = '0;

    // Position k within the started sequence decides every output arithmetically.
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            th = '0; m_active = 0; m_cont = 0; m_k = 0;
            exp_gate = 0; exp_busy = 0; exp_done = 0; exp_dac = '0; exp_count = '0;
        end else begin
            th = {th[2:0], bus.trigger};
`ifdef BURST_SEQUENCER_TRIG_SYNC_EN
            tedge = th[2] & ~th[3];
`else
            tedge = th[0] & ~th[1];
`endif
            if (!bus.enable) begin
                m_active = 0;
            end else if (m_active) begin
                m_k = m_k + 1;
                if (!m_cont && m_rep != 0 && m_k > m_total) m_active = 0;
            end else if (tedge) begin
                m_delay = longint'(bus.cfg_delay);
                m_on    = longint'(bus.cfg_on);
                m_off   = longint'(bus.cfg_off);
                m_rep   = longint'(bus.cfg_repeat);
                m_cont  = (m_on == 0);
                m_k     = 0;
                m_total = m_delay + (m_rep - 1) * (m_on + m_off) + m_on;
                exp_count = '0;
                m_active = 1;
            end
            exp_gate = 0; exp_busy = 0; exp_done = 0;
            if (m_active) begin
                exp_busy = 1;
                if (m_cont) begin
                    exp_gate = 1;
                end else if (m_rep != 0 && m_k == m_total) begin
                    exp_done  = 1;
                    exp_count = 32'(m_rep);
                end else if (m_k >= m_delay) begin
                    j   = m_k - m_delay;
                    per = m_on + m_off;
                    ph  = j % per;
                    exp_gate  = (ph < m_on);
                    exp_count = 32'(j / per + ((ph >= m_on) ? 1 : 0));
                end
            end
            exp_dac = exp_gate ? bus.dac_data : '0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("gate",        64'(bus.gate),        64'(exp_gate));
        check("dac_out",     64'(bus.dac_out),     64'(exp_dac));
        check("busy",        64'(bus.busy),        64'(exp_busy));
        check("done",        64'(bus.done),        64'(exp_done));
        check("burst_count", 64'(bus.burst_count), 64'(exp_count));
    end

    // Free-running sample stream.
    initial begin
        bus.dac_data = '0;
        forever begin
            @(negedge clk);
            bus.dac_data = 14'($urandom);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_cfg(input int d, input int on, input int off, input int rep);
        bus.cfg_delay  = 32'(d);
        bus.cfg_on     = 32'(on);
        bus.cfg_off    = 32'(off);
        bus.cfg_repeat = 32'(rep);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise trigger in cycle t, then record outputs of cycles t+1..t+n (bit i = cycle t+i).
    task automatic run_seq(input logic [63:0] trig_pat, input int n,
                           output logic [63:0] gm, output logic [63:0] dm, output logic [63:0] bm);
        gm = '0; dm = '0; bm = '0;
        @(negedge clk);
        bus.trigger = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            gm[i] = bus.gate;
            dm[i] = bus.done;
            bm[i] = bus.busy;
            bus.trigger = trig_pat[i];
        end
    endtask

    logic [63:0] gm, dm, bm, ex, pat;
    logic        seen_done;

    initial begin
        bus.enable = 1'b1;
        bus.trigger = 1'b0;
        set_cfg(0, 0, 0, 0);
        #1 areset = 1'b1;
        #1;
        check("reset_gate",  64'(bus.gate), 64'd0);
        check("reset_busy",  64'(bus.busy), 64'd0);
        check("reset_dac",   64'(bus.dac_out), 64'd0);
        check("reset_count", 64'(bus.burst_count), 64'd0);
        repeat (3) @(negedge clk);
        #1 areset = 1'b0;
        idle(4);

        // Delayed two-burst train.
        set_cfg(3, 4, 2, 2);
        run_seq(64'd0, 24, gm, dm, bm);
        ex = 64'h3CF0;                     ex = ex << SH; check("s1_gate_mask", gm, ex);
        ex = 64'd1 << (14 + SH);           check("s1_done_mask", dm, ex);
        ex = (64'd1 << 15) - 64'd2;        ex = ex << SH; check("s1_busy_mask", bm, ex);
        check("s1_count", 64'(bus.burst_count), 64'd2);
        idle(4);

        // Continuous mode then enable drop.
        set_cfg(2, 0, 3, 1);
        run_seq(64'd0, 50, gm, dm, bm);
        ex = ((64'd1 << 51) - 64'd1) & ~((64'd1 << (SH + 1)) - 64'd1);
        check("s2_gate_mask", gm, ex);
        check("s2_no_done", dm, 64'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        check("s2_gate_off", 64'(bus.gate), 64'd0);
        check("s2_count", 64'(bus.burst_count), 64'd0);
        bus.enable = 1'b1;
        idle(4);

        // Back-to-back bursts without gap.
        set_cfg(0, 5, 0, 3);
        run_seq(64'd0, 24, gm, dm, bm);
        ex = (64'd1 << 16) - 64'd2;        ex = ex << SH; check("s3_gate_mask", gm, ex);
        ex = 64'd1 << (16 + SH);           check("s3_done_mask", dm, ex);
        idle(4);

        // Abort during the second of four bursts.
        set_cfg(0, 4, 2, 4);
        run_seq(64'd0, 8 + SH, gm, dm, bm);
        check("s4_no_done_pre", dm, 64'd0);
        bus.enable = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_done = seen_done | bus.done;
        end
        check("s4_no_done", 64'(seen_done), 64'd0);
        check("s4_busy", 64'(bus.busy), 64'd0);
        check("s4_count", 64'(bus.burst_count), 64'd1);
        bus.enable = 1'b1;
        idle(4);

        // Retrigger pulses while busy are ignored.
        set_cfg(1, 3, 2, 2);
        pat = (64'd1 << 3) | (64'd1 << 6);
        run_seq(pat, 20, gm, dm, bm);
        ex = 64'h39C;                      ex = ex << SH; check("s4_retrig_gate", gm, ex);
        ex = 64'd1 << (10 + SH);           check("s4_retrig_done", dm, ex);
        idle(4);

        // Asynchronous reset mid-gap, then a clean restart.
        set_cfg(0, 3, 5, 2);
        run_seq(64'd0, 5 + SH, gm, dm, bm);
        #2 areset = 1'b1;
        #1;
        check("s5_gate",  64'(bus.gate), 64'd0);
        check("s5_busy",  64'(bus.busy), 64'd0);
        check("s5_dac",   64'(bus.dac_out), 64'd0);
        check("s5_done",  64'(bus.done), 64'd0);
        check("s5_count", 64'(bus.burst_count), 64'd0);
        #1 areset = 1'b0;
        set_cfg(0, 5, 0, 3);
        run_seq(64'd0, 24, gm, dm, bm);
        ex = (64'd1 << 16) - 64'd2;        ex = ex << SH; check("s5_restart_gate", gm, ex);
        check("s5_restart_count", 64'(bus.burst_count), 64'd3);
        idle(4);

        // Trigger held high across DONE must not restart.
        set_cfg(0, 2, 0, 1);
        run_seq(~64'd0, 20, gm, dm, bm);
        ex = 64'hE;                        ex = ex << SH; check("s6_held_busy", bm, ex);
        bus.trigger = 1'b0;
        idle(4);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.trigger = ~bus.trigger;
            if (bus.enable) begin
                if ($urandom_range(0, 59) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.enable = 1'b1;
            end
            bus.cfg_delay  = 32'($urandom_range(0, 3));
            bus.cfg_on     = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 5));
            bus.cfg_off    = 32'($urandom_range(0, 3));
            bus.cfg_repeat = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                #1 areset = 1'b1;
                #2 areset = 1'b0;
            end
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_sequencer.md
Name: burst_sequencer

Overview:
Trigger-driven controller that gates the 14-bit DAC sample stream into a programmable train of bursts.
- Sequence per start: start delay, then cfg_repeat bursts of cfg_on samples, separated by cfg_off samples of zero output.
- Sits between the waveform generator and the DAC output stage.
- Signal generation is not modified; output is either passed or forced to zero.
- Configuration comes from the system config register bank.

Parameters:
- CFG_DATA_WIDTH, 32, width of all length, delay and repeat fields and of burst_count.
- DAC_WIDTH, 14, sample width.

Ports:
- clk  in  1  system clock.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  level; low aborts any sequence and forces idle.
- trigger  in  1  start request; rising edge is active.
- dac_data  in  DAC_WIDTH  sample stream from the generator.
- cfg_delay  in  CFG_DATA_WIDTH  cycles from trigger to first burst.
- cfg_on  in  CFG_DATA_WIDTH  burst length in cycles; 0 selects continuous mode.
- cfg_off  in  CFG_DATA_WIDTH  gap length in cycles.
- cfg_repeat  in  CFG_DATA_WIDTH  number of bursts; 0 means infinite.
- dac_out  out  DAC_WIDTH  gated samples.
- gate  out  1  high while dac_out carries data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at normal sequence completion.
- burst_count  out  CFG_DATA_WIDTH  number of completed bursts in the current sequence.

Behaviour:
- Reset: areset clears everything asynchronously; the state machine goes to IDLE.
  - Every output is 0 and the counters and trigger history are cleared.
  - A reset mid-sequence behaves identically; the sequence is lost.
- Trigger edge: trig_edge = trigger & ~trig_q, where trig_q is a registered copy of trigger.
- Configuration latch: cfg_* are latched on the start cycle only. Later cfg changes affect the next sequence only.
- State machine states: IDLE, DELAY, ON, OFF, CONT, DONE. Transitions:
  - IDLE: on enable & trig_edge, latch cfg and clear burst_count. Next state is CONT if cfg_on==0, else DELAY if cfg_delay!=0, else ON.
  - DELAY: stays exactly cfg_delay cycles, then goes to ON.
  - ON: stays exactly cfg_on cycles.
    - On the last cycle burst_count increments.
    - If cfg_repeat!=0 and the new count equals cfg_repeat, go to DONE.
    - Otherwise go to OFF if cfg_off!=0, else ON again with no gap.
  - OFF: stays exactly cfg_off cycles, then goes to ON.
  - CONT: gate stays high until enable falls. burst_count stays 0 and done never pulses.
  - DONE: lasts one cycle with done=1, then returns to IDLE.
- Abort: enable low in any state returns to IDLE on the next edge. gate drops and dac_out becomes 0; done is not asserted; burst_count holds its value.
  - enable low on the trigger cycle wins, so no start occurs.
- Retrigger: trigger edges while busy are ignored. Trigger history still updates, so a trigger held high does not restart after DONE.
- Output registration:
  - gate is registered and high exactly in ON and CONT cycles.
  - dac_out <= next_gate ? dac_data : 0, giving one cycle of latency from dac_data.
- Timing example: with trig_edge at cycle t and cfg_delay=0, gate is high in cycles t+1 .. t+cfg_on.
- Counter width:
  - Counters are CFG_DATA_WIDTH wide and compare against latched length-1.
  - burst_count saturates at all-ones in infinite mode; it does not wrap.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: BURST_SEQUENCER_TRIG_SYNC_EN.
- Defined: trigger passes through a 2-flop synchronizer (reset to 0) before edge detection. This supports an asynchronous external trigger pin, and all trigger-referenced timing shifts by +2 cycles.
- Undefined: trigger is assumed synchronous to clk and is used directly.

Decomposition:
- Shared package burst_pkg holds:
  - the state encoding typedef: IDLE=0, DELAY=1, ON=2, OFF=3, CONT=4, DONE=5;
  - DAC_WIDTH_DEFAULT=14;
  - CFG_WIDTH_DEFAULT=32.
- One natural sub-module: burst_trig_detect, containing the optional synchronizer plus the edge detector, outputting trig_edge.
- The state machine, counters and output register stay in burst_sequencer.

Test Plan:
1. cfg_delay=3, cfg_on=4, cfg_off=2, cfg_repeat=2, trigger edge at cycle 10.
   - gate high in cycles 14-17 and 20-23.
   - done pulse at cycle 24; busy low from 25; burst_count=2.
   - dac_out equals dac_data delayed by 1 while gated, 0 otherwise.
2. cfg_on=0, trigger edge, then enable low after 50 cycles.
   - gate high continuously, then low one cycle after enable falls.
   - no done pulse; burst_count=0.
3. cfg_off=0, cfg_on=5, cfg_repeat=3, cfg_delay=0.
   - gate high for 15 consecutive cycles starting at t+1.
   - done pulse at t+16.
4. Abort and retrigger handling:
   - enable low mid-ON during burst 2 of 4: return to IDLE, no done, burst_count=1.
   - trigger pulses while busy: ignored, sequence timing unchanged.
5. areset pulsed asynchronously mid-OFF: all outputs 0 immediately; a new trigger afterwards starts a clean sequence.
6. With BURST_SEQUENCER_TRIG_SYNC_EN defined, repeat scenario 1: all edges shift by +2 cycles.
   - Trigger held high across DONE causes no restart.
